// File: rtl/fc_seq_ctrl.sv
// Fully-connected layer sequencer: result = data x weight + bias computed on one
// shared multiply-accumulate unit, streaming one result per (row, column) pair.
module fc_seq_ctrl #(
  parameter int unsigned batch_size   = 1,
  parameter int unsigned feature_size = 3,
  parameter int unsigned bias_size    = 2,
  parameter int unsigned addr_w       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [addr_w-1:0] d_addr,
  output logic [addr_w-1:0] w_addr,
  output logic [addr_w-1:0] b_addr,
  input  logic [31:0]       d_rdata,
  input  logic [31:0]       w_rdata,
  input  logic [31:0]       b_rdata,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [15:0]       res_row,
  output logic [15:0]       res_col
);

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    OUT,
    DONE
  } state_t;

  localparam logic [15:0] last_row = 16'(batch_size - 1);
  localparam logic [15:0] last_col = 16'(bias_size - 1);
  localparam logic [15:0] last_k   = 16'(feature_size - 1);

  state_t      state, state_nxt;
  logic [15:0] i, i_nxt;
  logic [15:0] j, j_nxt;
  logic [15:0] k, k_nxt;
  logic [31:0] acc, acc_nxt;
  logic [31:0] prod;

  logic              busy_nxt;
  logic              done_nxt;
  logic              rd_en_nxt;
  logic [addr_w-1:0] d_addr_nxt;
  logic [addr_w-1:0] w_addr_nxt;
  logic [addr_w-1:0] b_addr_nxt;
  logic              res_valid_nxt;
  logic [31:0]       res_data_nxt;
  logic [15:0]       res_row_nxt;
  logic [15:0]       res_col_nxt;

  // Operands arriving this cycle were requested one step earlier, so the
  // product always belongs to the previous k.
  assign prod = d_rdata * w_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      acc       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      d_addr    <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
    end else begin
      state     <= state_nxt;
      i         <= i_nxt;
      j         <= j_nxt;
      k         <= k_nxt;
      acc       <= acc_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      rd_en     <= rd_en_nxt;
      d_addr    <= d_addr_nxt;
      w_addr    <= w_addr_nxt;
      b_addr    <= b_addr_nxt;
      res_valid <= res_valid_nxt;
      res_data  <= res_data_nxt;
      res_row   <= res_row_nxt;
      res_col   <= res_col_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    i_nxt     = i;
    j_nxt     = j;
    k_nxt     = k;
    acc_nxt   = acc;

    case (state)
      IDLE: begin
        if (start) begin
          i_nxt     = '0;
          j_nxt     = '0;
          k_nxt     = '0;
          state_nxt = BIAS;
        end
      end
      BIAS: begin
        k_nxt     = '0;
        state_nxt = MAC;
      end
      MAC: begin
        if (k == 16'd0) begin
          acc_nxt = b_rdata;
        end else begin
          acc_nxt = acc + prod;
        end
        k_nxt = k + 16'd1;
        if (k == last_k) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        acc_nxt   = acc + prod;
        state_nxt = OUT;
      end
      OUT: begin
        if (res_ready) begin
          if (j == last_col) begin
            j_nxt = '0;
            if (i == last_row) begin
              i_nxt     = '0;
              state_nxt = DONE;
            end else begin
              i_nxt     = i + 16'd1;
              state_nxt = BIAS;
            end
          end else begin
            j_nxt     = j + 16'd1;
            state_nxt = BIAS;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs are registered from the upcoming state so they line up with the
  // state itself while staying glitch-free; addresses hold when not reading.
  always_comb begin
    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state_nxt == DONE);
    rd_en_nxt     = (state_nxt == BIAS) || (state_nxt == MAC);
    res_valid_nxt = (state_nxt == OUT);
    d_addr_nxt    = d_addr;
    w_addr_nxt    = w_addr;
    b_addr_nxt    = b_addr;
    res_data_nxt  = res_data;
    res_row_nxt   = res_row;
    res_col_nxt   = res_col;

    if (state_nxt == BIAS) begin
      b_addr_nxt = addr_w'(j_nxt);
    end
    if (state_nxt == MAC) begin
      d_addr_nxt = addr_w'(32'(i_nxt) * feature_size + 32'(k_nxt));
      w_addr_nxt = addr_w'(32'(k_nxt) * bias_size + 32'(j_nxt));
    end
    if (state_nxt == OUT) begin
      res_data_nxt = acc_nxt;
      res_row_nxt  = i_nxt;
      res_col_nxt  = j_nxt;
    end
  end

endmodule
